cp0_regs: RTL
=============

# cp0_regs

Coprocessor-0 register file at the writeback end of the CPU pipeline. It receives the CP0 write stream that the MEM-to-WB stage register delivers (write enable, address, data, bad address). It also takes exception/ERET events and hardware interrupt lines. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and runs the Count/Compare timer. It presents the interrupt request and register contents back to the pipeline.

## Interface
- PRID_VALUE, 32'h0042_0020, value read at address 15.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- we_i  in  1  CP0 write enable from WB stage.
- waddr_i  in  5  CP0 write register number.
- wdata_i  in  32  CP0 write data.
- raddr_i  in  5  CP0 read register number (MFC0 path).
- rdata_o  out  32  read data, combinational.
- int_i  in  6  hardware interrupt lines, level-sensitive.
- exc_valid_i  in  1  exception commit this cycle.
- exc_code_i  in  5  ExcCode of committing exception.
- exc_pc_i  in  32  PC of faulting instruction.
- exc_bd_i  in  1  faulting instruction is in a delay slot.
- exc_bad_addr_i  in  32  faulting address (AdEL/AdES).
- eret_i  in  1  ERET commit this cycle.
- status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  out  32 each  current register values.
- timer_int_o  out  1  sticky timer interrupt flag.
- int_req_o  out  1  pending enabled interrupt, combinational from registers.

## Operation
- Addresses: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId (read-only). All other addresses read 0 and ignore writes.
- Reset values:
  - Status = 32'h0040_0000 (BEV=1).
  - All other registers = 0.
  - timer_int_o = 0.
  - Internal tick = 0.
- Writable bits:
  - Status: only IM[15:8], EXL[1] and IE[0]; all other bits hold.
  - Cause: only IP[9:8] (software interrupts).
  - Count, Compare, EPC: full 32 bits.
  - BadVAddr: not writable by software.
- Count: the tick flop toggles every cycle, and Count increments (wrapping 32'hFFFF_FFFF -> 0) on cycles where tick=1, i.e. once per 2 cycles. A Count write loads wdata_i and clears tick; the increment is suppressed that cycle.
- Timer:
  - Set: timer_int_o sets when Compare != 0 and Count == Compare.
  - Sticky: it stays set until a Compare write.
  - Clear: a Compare write clears it; if the set condition also holds that cycle, the clear wins.
- Cause.IP[15:10] are sampled every cycle as {int_i[5] | timer_int_o, int_i[4:0]}. They are read-only.
- Exception (exc_valid_i=1):
  - When Status.EXL=0: EPC <= exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD[31] <= exc_bd_i.
  - When EXL=1: EPC and BD hold.
  - Always: Status.EXL <= 1 and Cause.ExcCode[6:2] <= exc_code_i.
  - If exc_code_i is 4 (AdEL) or 5 (AdES): BadVAddr <= exc_bad_addr_i.
- ERET: Status.EXL <= 0.
- Simultaneous events:
  - The we_i write is applied first. Exception/ERET updates then override any field they touch.
  - exc_valid_i has priority over eret_i.
- rdata_o: if we_i and waddr_i == raddr_i, return wdata_i (bypass); otherwise return the register value.
- int_req_o = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]).

## Timing
- All register updates become visible on status_o/cause_o/etc. one cycle after the input edge.
- rdata_o and int_req_o are zero-latency combinational.
- Reset asserted mid-operation forces all reset values immediately, independent of the clock.
- After reset deassertion, the first Count increment occurs on the second rising edge.

## Test plan
- Reset, then idle 10 cycles -> Count=5, Status=0x0040_0000, Cause=0, int_req_o=0.
- Write Compare=3, then idle -> timer_int_o rises the cycle after Count reaches 3, with Cause[15]=1. A subsequent Compare write clears it the next cycle.
- Status write 0xFFFF_FFFF -> Status reads 0x0040_FF03. A Cause write 0xFFFF_FFFF -> only Cause[9:8] set, and int_req_o=0 because EXL=1.
- Exception: code 4, pc 0xBFC0_0100, bd=1, bad 0x1234_5671 -> EPC=0xBFC0_00FC, Cause.BD=1, ExcCode=4, BadVAddr=0x1234_5671, EXL=1. A second exception while EXL=1 leaves EPC unchanged. ERET clears EXL.
- Same-cycle we_i (Status=0x0000_0001) and exc_valid_i -> Status=0x0040_0003. Read bypass: raddr=waddr=14 returns wdata_i.
- Count write 0xFFFF_FFFF, then idle -> Count wraps to 0 after 2 cycles. Reset asserted mid-count returns Count to 0 without a clock edge.

Source files
------------

// File: rtl/cp0_regs.sv
// ---------------------------------------------------------------------------
// cp0_regs
//
// Coprocessor-0 register file that sits at the writeback end of the pipeline.
// It holds BadVAddr, Count, Compare, Status, Cause and EPC, runs the
// Count/Compare timer, records exception state and raises the interrupt
// request seen by the pipeline.
//
// Ports
//   clk_i           clock, all state changes on the rising edge
//   rst_i           asynchronous active-high reset
//   we_i            CP0 write enable (MTC0 arriving from WB)
//   waddr_i         CP0 register number being written
//   wdata_i         CP0 write data
//   raddr_i         CP0 register number being read (MFC0)
//   rdata_o         combinational read data, bypasses a same-cycle write
//   int_i           hardware interrupt lines, level sensitive
//   exc_valid_i     an exception commits this cycle
//   exc_code_i      ExcCode of the committing exception
//   exc_pc_i        PC of the faulting instruction
//   exc_bd_i        faulting instruction sits in a branch delay slot
//   exc_bad_addr_i  faulting virtual address for AdEL/AdES
//   eret_i          an ERET commits this cycle
//   status_o ..     current register values
//   timer_int_o     sticky Count/Compare match flag
//   int_req_o       an enabled interrupt is pending
// ---------------------------------------------------------------------------
module cp0_regs #(
  parameter logic [31:0] PRID_VALUE = 32'h0042_0020
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_bd_i,
  input  logic [31:0] exc_bad_addr_i,
  input  logic        eret_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o,
  output logic        int_req_o
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  // Software-writable bits: Status IM[15:8], EXL, IE; Cause IP[9:8].
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic [31:0] status_q,   status_d;
  logic [31:0] cause_q,    cause_d;
  logic [31:0] epc_q,      epc_d;
  logic        tick_q,     tick_d;
  logic        timer_q,    timer_d;

  logic        wrCount;
  logic        wrCompare;
  logic        wrStatus;
  logic        wrCause;
  logic        wrEpc;
  logic        excLatchesBadAddr;
  logic        timerMatch;
  logic [31:0] excEpc;
  logic [31:0] regRead;

  // Address decode of the WB write stream plus the exception-derived values
  // that several registers share.
  always_comb begin
    wrCount           = we_i && (waddr_i == ADDR_COUNT);
    wrCompare         = we_i && (waddr_i == ADDR_COMPARE);
    wrStatus          = we_i && (waddr_i == ADDR_STATUS);
    wrCause           = we_i && (waddr_i == ADDR_CAUSE);
    wrEpc             = we_i && (waddr_i == ADDR_EPC);
    excLatchesBadAddr = exc_valid_i &&
                        ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES));
    // A delay-slot fault restarts at the branch, one word earlier.
    excEpc            = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
    timerMatch        = (compare_q != 32'd0) && (count_q == compare_q);
  end

  // Count runs at half the clock rate: the tick flop alternates and Count
  // advances on the cycles where it is high. Loading Count restarts the
  // half-rate phase so the loaded value is held for two full cycles.
  always_comb begin
    tick_d  = ~tick_q;
    count_d = count_q;
    if (wrCount) begin
      count_d = wdata_i;
      tick_d  = 1'b0;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end
  end

  // Compare register and the sticky timer flag. Writing Compare is the only
  // way to acknowledge the timer, and it beats a match in the same cycle.
  always_comb begin
    compare_d = compare_q;
    timer_d   = timer_q;
    if (timerMatch) begin
      timer_d = 1'b1;
    end
    if (wrCompare) begin
      compare_d = wdata_i;
      timer_d   = 1'b0;
    end
  end

  // Status: the software write lands first, then an exception sets EXL or an
  // ERET clears it. An exception outranks an ERET committing alongside it.
  always_comb begin
    status_d = status_q;
    if (wrStatus) begin
      status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
    end
    if (exc_valid_i) begin
      status_d[EXL_BIT] = 1'b1;
    end else if (eret_i) begin
      status_d[EXL_BIT] = 1'b0;
    end
  end

  // Cause: software may only touch the two soft-interrupt bits. An exception
  // records ExcCode always, but BD only for the first exception (EXL clear),
  // so a nested fault does not lose the original restart information. The
  // hardware pending bits are resampled every cycle, with the timer folded
  // onto line 5.
  always_comb begin
    cause_d = cause_q;
    if (wrCause) begin
      cause_d = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
    end
    if (exc_valid_i) begin
      if (!status_q[EXL_BIT]) begin
        cause_d[BD_BIT] = exc_bd_i;
      end
      cause_d[6:2] = exc_code_i;
    end
    cause_d[15:10] = {int_i[5] | timer_q, int_i[4:0]};
  end

  // EPC follows the same first-exception-only rule as BD; BadVAddr captures
  // the faulting address for address-error exceptions only.
  always_comb begin
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (wrEpc) begin
      epc_d = wdata_i;
    end
    if (exc_valid_i && !status_q[EXL_BIT]) begin
      epc_d = excEpc;
    end
    if (excLatchesBadAddr) begin
      badvaddr_d = exc_bad_addr_i;
    end
  end

  // State register bank with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      tick_q     <= 1'b0;
      timer_q    <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      tick_q     <= tick_d;
      timer_q    <= timer_d;
    end
  end

  // MFC0 read mux. Unimplemented addresses read as zero.
  always_comb begin
    regRead = 32'd0;
    case (raddr_i)
      ADDR_BADVADDR: regRead = badvaddr_q;
      ADDR_COUNT:    regRead = count_q;
      ADDR_COMPARE:  regRead = compare_q;
      ADDR_STATUS:   regRead = status_q;
      ADDR_CAUSE:    regRead = cause_q;
      ADDR_EPC:      regRead = epc_q;
      ADDR_PRID:     regRead = PRID_VALUE;
      default:       regRead = 32'd0;
    endcase
  end

  // A write to the register being read in the same cycle is forwarded so the
  // pipeline never sees stale data.
  assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : regRead;

  assign int_req_o = status_q[IE_BIT] & ~status_q[EXL_BIT] &
                     (|(cause_q[15:8] & status_q[15:8]));

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_q;

endmodule
